binop_sequencer: RTL and testbench

- Sequences one WebAssembly binary numeric instruction (i32/i64/f32/f64 add, sub, mul, ...) between the operand stack and the shared ALU.
- On start it pops operand b, then a, and checks both types. It issues a op b to the ALU with a valid/ready handshake, waits for the result, then pushes the result back onto the stack.
- Sits between the instruction decoder and the stack/ALU. It reports a done pulse, or a sticky trap code, to the CPU control unit.

---
 rtl/binop_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_binop_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binop_sequencer.sv
// binop_sequencer
// ---------------
// Runs one WebAssembly binary numeric instruction between the operand stack
// and the shared ALU. Each instruction goes through these steps:
//   1. Pop b, then pop a, checking each type against the type latched at start.
//   2. Issue "a op b" to the ALU.
//   3. Wait for the ALU result.
//   4. Push the result back onto the stack.
// It reports a one-cycle done pulse, or a trap code that stays set until reset.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-low reset
//   start             begin an instruction (sampled only in IDLE)
//   opcode, exp_type  instruction opcode and expected operand type, latched on start
//   busy, done, trap  status to the CPU control unit (trap: 0 = none)
//   stack_*           pop request plus top-of-stack view; push request plus push data/type
//   alu_*             request channel (valid/ready, op, a, b) and result channel
//   dbg_state         current FSM state, for observation only
//
// Handshake: an ALU request transfers on a rising edge where alu_valid and
// alu_ready are both high. alu_valid, alu_op, alu_a and alu_b hold steady
// until that edge. alu_res_valid needs no ready; alu_result and alu_trap
// count only in a cycle where alu_res_valid is high.
//
// Trap codes: 1 = stack underflow, 2 = type mismatch, 4 = ALU timeout.
// A nonzero alu_trap is passed through unchanged.
module binop_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    opcode,
  input  logic [1:0]    exp_type,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] trap,
  output logic          stack_pop,
  input  logic [63:0]   stack_data,
  input  logic [1:0]    stack_type,
  input  logic          stack_empty,
  output logic          stack_push,
  output logic [63:0]   push_data,
  output logic [1:0]    push_type,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [7:0]    alu_op,
  output logic [63:0]   alu_a,
  output logic [63:0]   alu_b,
  input  logic          alu_res_valid,
  input  logic [63:0]   alu_result,
  input  logic [TW-1:0] alu_trap,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP_B = 3'd1,
    POP_A = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    PUSH  = 3'd5,
    TRAP  = 3'd6
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TRAP_UNDERFLOW = TW'(1);
  localparam logic [TW-1:0] TRAP_TYPE      = TW'(2);
  localparam logic [TW-1:0] TRAP_TIMEOUT   = TW'(4);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    op_q;
  logic [1:0]    type_q;
  logic [63:0]   a_q;
  logic [63:0]   b_q;
  logic [63:0]   res_q;
  logic          busy_q;
  logic          done_q;
  logic          push_q;
  logic          valid_q;
  logic [TW-1:0] trap_q;

  logic pop_ok;
  logic timeout_hit;

  // The top entry may be taken only when it exists and has the expected type.
  assign pop_ok = !stack_empty && (stack_type == type_q);

  // Checked at the end of an ISSUE or WAIT cycle: true when this cycle is the
  // TIMEOUT-th one spent waiting on the ALU. The >= also covers a counter that
  // reached TIMEOUT on the same edge the request was accepted.
  assign timeout_hit = (cnt_q >= CW'(TIMEOUT - 1));

  // The stack shows its top entry combinationally and removes it on the edge
  // that ends a cycle where stack_pop is high. stack_pop must therefore be
  // decided within the POP cycle, from the entry the stack is showing then.
  // It is the only output decoded from the current state. A registered
  // version would fire one cycle late, while the stack still showed b to POP_A.
  assign stack_pop = ((state_q == POP_B) || (state_q == POP_A)) && pop_ok;

  assign busy       = busy_q;
  assign done       = done_q;
  assign trap       = trap_q;
  assign stack_push = push_q;
  assign push_data  = res_q;
  assign push_type  = type_q;
  assign alu_valid  = valid_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign dbg_state  = state_q;

  // Registered outputs are written together with the state they belong to.
  // Each such output is therefore high for exactly the cycles that state is active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      type_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      push_q  <= 1'b0;
      valid_q <= 1'b0;
      trap_q  <= '0;
    end else begin
      done_q <= 1'b0;
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= opcode;
            type_q  <= exp_type;
            busy_q  <= 1'b1;
            state_q <= POP_B;
          end
        end
        POP_B: begin
          if (stack_empty) begin
            trap_q  <= TRAP_UNDERFLOW;
            state_q <= TRAP;
          end else if (!pop_ok) begin
            trap_q  <= TRAP_TYPE;
            state_q <= TRAP;
          end else begin
            b_q     <= stack_data;
            state_q <= POP_A;
          end
        end
        POP_A: begin
          // b has already left the stack; a trap here is fatal, so it is not put back.
          if (stack_empty) begin
            trap_q  <= TRAP_UNDERFLOW;
            state_q <= TRAP;
          end else if (!pop_ok) begin
            trap_q  <= TRAP_TYPE;
            state_q <= TRAP;
          end else begin
            a_q     <= stack_data;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (alu_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + CW'(1);
            state_q <= WAIT;
          end else if (timeout_hit) begin
            valid_q <= 1'b0;
            trap_q  <= TRAP_TIMEOUT;
            state_q <= TRAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT: begin
          if (alu_res_valid) begin
            if (alu_trap != '0) begin
              trap_q  <= alu_trap;
              state_q <= TRAP;
            end else begin
              res_q   <= alu_result;
              push_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= PUSH;
            end
          end else if (timeout_hit) begin
            trap_q  <= TRAP_TIMEOUT;
            state_q <= TRAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PUSH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        TRAP: begin
          // Terminal until reset: the trap code holds, busy stays high and start is ignored.
          state_q <= TRAP;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binop_sequencer.sv
// Directed testbench for binop_sequencer.
// A behavioural stack and ALU sit around the DUT. The main initial block runs
// each scenario in turn and compares against hand-computed values.
module tb_binop_sequencer;

  localparam int TW = 4;
  localparam logic [1:0] T_I32 = 2'd0;
  localparam logic [1:0] T_I64 = 2'd1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    opcode;
  logic [1:0]    exp_type;
  logic          busy;
  logic          done;
  logic [TW-1:0] trap;
  logic          stack_pop;
  logic [63:0]   stack_data;
  logic [1:0]    stack_type;
  logic          stack_empty;
  logic          stack_push;
  logic [63:0]   push_data;
  logic [1:0]    push_type;
  logic          alu_valid;
  logic          alu_ready;
  logic [7:0]    alu_op;
  logic [63:0]   alu_a;
  logic [63:0]   alu_b;
  logic          alu_res_valid;
  logic [63:0]   alu_result;
  logic [TW-1:0] alu_trap;
  logic [2:0]    dbg_state;

  binop_sequencer #(.TIMEOUT(64), .TW(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .exp_type(exp_type),
    .busy(busy), .done(done), .trap(trap),
    .stack_pop(stack_pop), .stack_data(stack_data), .stack_type(stack_type),
    .stack_empty(stack_empty), .stack_push(stack_push), .push_data(push_data),
    .push_type(push_type), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res_valid(alu_res_valid),
    .alu_result(alu_result), .alu_trap(alu_trap), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stack model ----------------
  logic [63:0] st_data [16];
  logic [1:0]  st_type [16];
  logic [4:0]  st_cnt;
  logic [3:0]  top_idx;

  assign top_idx     = 4'(st_cnt - 5'd1);
  assign stack_empty = (st_cnt == 5'd0);
  assign stack_data  = stack_empty ? 64'd0 : st_data[top_idx];
  assign stack_type  = stack_empty ? 2'd0 : st_type[top_idx];

  always @(posedge clk) begin
    if (stack_pop && st_cnt != 5'd0) begin
      st_cnt <= st_cnt - 5'd1;
    end else if (stack_push) begin
      st_data[st_cnt[3:0]] <= push_data;
      st_type[st_cnt[3:0]] <= push_type;
      st_cnt <= st_cnt + 5'd1;
    end
  end

  // ---------------- ALU model ----------------
  int            cfg_ready_delay;
  int            cfg_res_delay;
  bit            cfg_never;
  logic [63:0]   cfg_result;
  logic [TW-1:0] cfg_trap;
  int            alu_ph;
  int            wait_cnt;
  int            res_cnt;

  always @(negedge clk) begin
    alu_ready     = 1'b0;
    alu_res_valid = 1'b0;
    alu_trap      = '0;
    alu_result    = 64'd0;
    if (!reset) begin
      alu_ph   = 0;
      wait_cnt = 0;
      res_cnt  = 0;
    end else if (alu_ph == 0) begin
      if (!alu_valid) begin
        wait_cnt = 0;
      end else if (!cfg_never) begin
        if (wait_cnt >= cfg_ready_delay) begin
          alu_ready = 1'b1;
          alu_ph    = 1;
          res_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      if (res_cnt >= cfg_res_delay) begin
        alu_res_valid = 1'b1;
        alu_result    = cfg_result;
        alu_trap      = cfg_trap;
        alu_ph        = 0;
        wait_cnt      = 0;
      end else begin
        res_cnt++;
      end
    end
  end

  // ---------------- monitors ----------------
  int          pop_cnt = 0;
  int          push_cnt = 0;
  int          done_cnt = 0;
  int          valid_cnt = 0;
  int          unstable_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  prev_op;
  logic [63:0] prev_a;
  logic [63:0] prev_b;
  logic [7:0]  acc_op;
  logic [63:0] acc_a;
  logic [63:0] acc_b;

  always @(posedge clk) begin
    if (reset) begin
      if (stack_pop)  pop_cnt  <= pop_cnt + 1;
      if (stack_push) push_cnt <= push_cnt + 1;
      if (done)       done_cnt <= done_cnt + 1;
      if (alu_valid)  valid_cnt <= valid_cnt + 1;
      if (alu_valid && prev_valid &&
          (alu_op !== prev_op || alu_a !== prev_a || alu_b !== prev_b))
        unstable_cnt <= unstable_cnt + 1;
      if (alu_valid && alu_ready) begin
        acc_op <= alu_op;
        acc_a  <= alu_a;
        acc_b  <= alu_b;
      end
    end
    prev_valid <= alu_valid;
    prev_op    <= alu_op;
    prev_a     <= alu_a;
    prev_b     <= alu_b;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    st_cnt <= 5'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load(input logic [1:0] t, input logic [63:0] d);
    @(negedge clk);
    st_data[st_cnt[3:0]] <= d;
    st_type[st_cnt[3:0]] <= t;
    st_cnt <= st_cnt + 5'd1;
  endtask

  task automatic alu_cfg(input int rdy_dly, input int res_dly, input bit never,
                         input logic [63:0] res, input logic [TW-1:0] tr);
    cfg_ready_delay = rdy_dly;
    cfg_res_delay   = res_dly;
    cfg_never       = never;
    cfg_result      = res;
    cfg_trap        = tr;
  endtask

  // Raises start for one edge, then counts cycles: cycle 1 is the POP_B cycle.
  // Stops at the first done pulse or nonzero trap; a 0 return means never seen.
  task automatic run_op(input logic [7:0] op, input logic [1:0] ty, input int budget,
                        output int cyc_done, output int cyc_trap);
    @(negedge clk);
    start    = 1'b1;
    opcode   = op;
    exp_type = ty;
    cyc_done = 0;
    cyc_trap = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done && cyc_done == 0) cyc_done = c;
      if (trap != '0 && cyc_trap == 0) cyc_trap = c;
      if (cyc_done != 0 || cyc_trap != 0) break;
    end
  endtask

  // ---------------- directed sequence ----------------
  int cd;
  int ct;
  int p0;
  int q0;
  int v0;
  int d0;
  int u0;
  bit seen;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    opcode = 8'd0;
    exp_type = 2'd0;
    st_cnt = 5'd0;
    alu_cfg(0, 0, 1'b0, 64'd0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trap", trap, 0);
    check("rst_push", stack_push, 0);
    check("rst_valid", alu_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_push_data", push_data, 0);
    check("rst_state", dbg_state, 0);

    // i64.sub: stack 7 | 3 | 2 (top); ALU returns 1
    load(T_I64, 64'd7);
    load(T_I64, 64'd3);
    load(T_I64, 64'd2);
    alu_cfg(0, 0, 1'b0, 64'd1, '0);
    p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt;
    run_op(8'h7D, T_I64, 40, cd, ct);
    check("sub_done_cycle", cd, 5);
    check("sub_trap", trap, 0);
    check("sub_busy_in_push", busy, 1);
    check("sub_alu_op", acc_op, 8'h7D);
    check("sub_alu_a", acc_a, 3);
    check("sub_alu_b", acc_b, 2);
    @(negedge clk);
    check("sub_busy_after", busy, 0);
    check("sub_done_after", done, 0);
    check("sub_pops", pop_cnt - p0, 2);
    check("sub_pushes", push_cnt - q0, 1);
    check("sub_done_pulses", done_cnt - d0, 1);
    check("sub_stack_depth", st_cnt, 2);
    check("sub_stack_top", stack_data, 1);
    check("sub_stack_type", stack_type, T_I64);

    // Back-to-back: start in the IDLE cycle right after PUSH; 7 + 1 = 8
    alu_cfg(0, 0, 1'b0, 64'd8, '0);
    cfg_ready_delay = 0;
    start    = 1'b1;
    opcode   = 8'h7C;
    exp_type = T_I64;
    cd = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cd = c;
        break;
      end
    end
    check("b2b_done_cycle", cd, 5);
    check("b2b_alu_a", acc_a, 7);
    check("b2b_alu_b", acc_b, 1);
    @(negedge clk);
    check("b2b_stack_top", stack_data, 8);
    check("b2b_stack_depth", st_cnt, 1);

    // Underflow: one i64 entry
    do_reset();
    load(T_I64, 64'd9);
    p0 = pop_cnt; q0 = push_cnt; v0 = valid_cnt; d0 = done_cnt;
    run_op(8'h7C, T_I64, 40, cd, ct);
    check("uf_trap", trap, 1);
    check("uf_trap_cycle", ct, 3);
    check("uf_pops", pop_cnt - p0, 1);
    check("uf_valid", valid_cnt - v0, 0);
    // start is ignored once trapped
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("uf_trap_sticky", trap, 1);
    check("uf_busy_trap", busy, 1);
    check("uf_state_trap", dbg_state, 6);
    check("uf_pushes", push_cnt - q0, 0);
    check("uf_dones", done_cnt - d0, 0);
    check("uf_pops_after", pop_cnt - p0, 1);

    // Type mismatch: top is i32, expected i64
    do_reset();
    check("tm_trap_cleared", trap, 0);
    load(T_I64, 64'd1);
    load(T_I32, 64'd5);
    p0 = pop_cnt;
    run_op(8'h7C, T_I64, 40, cd, ct);
    check("tm_trap", trap, 2);
    check("tm_trap_cycle", ct, 2);
    check("tm_pops", pop_cnt - p0, 0);

    // ALU backpressure: ready held low for 10 cycles; 100 - 40 = 60
    do_reset();
    load(T_I64, 64'd100);
    load(T_I64, 64'd40);
    alu_cfg(10, 0, 1'b0, 64'd60, '0);
    v0 = valid_cnt; u0 = unstable_cnt;
    run_op(8'h7D, T_I64, 60, cd, ct);
    check("bp_done_cycle", cd, 15);
    check("bp_trap", trap, 0);
    check("bp_valid_cycles", valid_cnt - v0, 11);
    check("bp_stable", unstable_cnt - u0, 0);
    check("bp_alu_a", acc_a, 100);
    @(negedge clk);
    check("bp_result", stack_data, 60);

    // Timeout: ready never comes
    do_reset();
    load(T_I64, 64'd4);
    load(T_I64, 64'd5);
    alu_cfg(0, 0, 1'b1, 64'd0, '0);
    v0 = valid_cnt; q0 = push_cnt;
    run_op(8'h7E, T_I64, 120, cd, ct);
    check("to_trap", trap, 4);
    check("to_trap_cycle", ct, 67);
    check("to_valid_cycles", valid_cnt - v0, 64);
    check("to_valid_low", alu_valid, 0);
    check("to_pushes", push_cnt - q0, 0);

    // ALU trap 3 returned with the result
    do_reset();
    load(T_I64, 64'd4);
    load(T_I64, 64'd0);
    alu_cfg(0, 0, 1'b0, 64'd0, 4'd3);
    q0 = push_cnt; d0 = done_cnt;
    run_op(8'h7F, T_I64, 40, cd, ct);
    check("at_trap", trap, 3);
    check("at_trap_cycle", ct, 5);
    @(negedge clk);
    check("at_pushes", push_cnt - q0, 0);
    check("at_dones", done_cnt - d0, 0);

    // Reset while in WAIT, then a normal operation
    do_reset();
    load(T_I64, 64'd11);
    load(T_I64, 64'd22);
    alu_cfg(0, 1000, 1'b0, 64'd0, '0);
    @(negedge clk);
    start    = 1'b1;
    opcode   = 8'h7C;
    exp_type = T_I64;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (dbg_state == 3'd4) begin
        seen = 1'b1;
        break;
      end
    end
    check("rw_reached_wait", seen, 1);
    reset = 1'b0;
    st_cnt <= 5'd0;
    @(negedge clk);
    check("rw_state", dbg_state, 0);
    check("rw_busy", busy, 0);
    check("rw_trap", trap, 0);
    check("rw_valid", alu_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    load(T_I64, 64'd20);
    load(T_I64, 64'd22);
    alu_cfg(0, 0, 1'b0, 64'd42, '0);
    run_op(8'h7C, T_I64, 40, cd, ct);
    check("rw_done_cycle", cd, 5);
    check("rw_alu_b", acc_b, 22);
    @(negedge clk);
    check("rw_result", stack_data, 42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
